// File: rtl/perf_counter_pkg.sv
// Shared types and constants for the core performance-monitor block.
package perf_counter_pkg;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_RUN,
    PC_HALTED
  } pc_state_t;

  localparam int CYCLE_CNT_IDX = 0;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_0000;

endpackage

// File: rtl/perf_counter_cell.sv
// One up/down event counter with a sticky overflow flag.
// Decrements stop at zero, and increments either saturate or wrap.
module perf_counter_cell #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] q,
  output logic             ovf
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (inc && !dec) begin
        if (&q) begin
          ovf <= 1'b1;
          q   <= SATURATE ? q : '0;
        end else begin
          q <= q + 1'b1;
        end
      end else if (dec && !inc && (q != '0)) begin
        q <= q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Performance monitor: cycle counter plus NUM_EVT event counters, halt-word detector,
// snapshot bank and registered read port.
module perf_counter_unit
  import perf_counter_pkg::*;
#(
  parameter int          NUM_EVT   = 4,
  parameter int          CNT_W     = 32,
  parameter bit          SATURATE  = 1'b1,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD,
  parameter int          HALT_RUN  = 5,
  localparam int         AW        = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_inc_i,
  input  logic [NUM_EVT-1:0] evt_dec_i,
  input  logic [31:0]        instr_i,
  input  logic               snap_i,
  input  logic [AW-1:0]      rd_addr_i,
  input  logic               rd_shadow_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               running_o,
  output logic               done_o
);

  pc_state_t        state;
  logic [7:0]       runCnt;
  logic             countEn;
  logic             haltWordSeen;
  logic             haltHit;
  logic [CNT_W-1:0] liveCnt   [NUM_EVT+1];
  logic [CNT_W-1:0] shadowCnt [NUM_EVT+1];
  logic [NUM_EVT:0] ovfVec;
  logic [CNT_W-1:0] rdSel;

  assign countEn      = (state == PC_RUN);
  assign haltWordSeen = (instr_i == HALT_WORD);
  // Halt fires on the edge that samples the HALT_RUN-th consecutive match.
  assign haltHit      = countEn && haltWordSeen && (runCnt == 8'(HALT_RUN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PC_IDLE;
      runCnt    <= '0;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else if (clear_i) begin
      state     <= PC_IDLE;
      runCnt    <= '0;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state)
        PC_IDLE: begin
          runCnt <= '0;
          if (start_i) begin
            state     <= PC_RUN;
            running_o <= 1'b1;
            done_o    <= 1'b0;
          end
        end
        PC_RUN: begin
          if (stop_i || haltHit) begin
            state     <= PC_HALTED;
            runCnt    <= '0;
            running_o <= 1'b0;
            done_o    <= 1'b1;
          end else if (haltWordSeen) begin
            runCnt <= (runCnt < 8'(HALT_RUN)) ? runCnt + 8'd1 : runCnt;
          end else begin
            runCnt <= '0;
          end
        end
        default: begin
          runCnt <= '0;
        end
      endcase
    end
  end

  for (genvar k = 0; k <= NUM_EVT; k++) begin : gCell
    logic cellInc;
    logic cellDec;
    if (k == CYCLE_CNT_IDX) begin : gCycle
      assign cellInc = 1'b1;
      assign cellDec = 1'b0;
    end else begin : gEvt
      assign cellInc = evt_inc_i[k-1];
      assign cellDec = evt_dec_i[k-1];
    end
    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) uCell (
      .clk   (clk),
      .reset (reset),
      .en    (countEn),
      .inc   (cellInc),
      .dec   (cellDec),
      .clr   (clear_i),
      .q     (liveCnt[k]),
      .ovf   (ovfVec[k])
    );
  end

  assign ovf_o = ovfVec;

  // Shadow captures live values as they stand before this cycle's counter update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= NUM_EVT; k++) shadowCnt[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k <= NUM_EVT; k++) shadowCnt[k] <= '0;
    end else if (snap_i) begin
      for (int k = 0; k <= NUM_EVT; k++) shadowCnt[k] <= liveCnt[k];
    end
  end

  always_comb begin
    rdSel = '0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (rd_addr_i == AW'(k)) rdSel = rd_shadow_i ? shadowCnt[k] : liveCnt[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_o <= '0;
    else       rd_data_o <= rdSel;
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: one 32-bit saturating instance and two 8-bit
// instances (saturating and wrapping) driven by the same stimulus; reads go through a queue.
module tb_perf_counter_unit;

  localparam int NE = 4;
  localparam int AW = 3;

  typedef struct {
    int          addr;
    bit          sh;
    logic [31:0] eMain;
    logic [7:0]  eSat;
    logic [7:0]  eWrap;
  } rdExp_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stop;
  logic          clear;
  logic [NE-1:0] evtInc;
  logic [NE-1:0] evtDec;
  logic [31:0]   instr;
  logic          snap;
  logic [AW-1:0] rdAddr;
  logic          rdShadow;

  logic [31:0]   rdMain;
  logic [7:0]    rdSat;
  logic [7:0]    rdWrap;
  logic [NE:0]   ovfMain, ovfSat, ovfWrap;
  logic          runMain, runSat, runWrap;
  logic          doneMain, doneSat, doneWrap;

  rdExp_t rdQ[$];
  int     total  = 0;
  int     passed = 0;

  perf_counter_unit #(.NUM_EVT(NE), .CNT_W(32), .SATURATE(1'b1), .HALT_WORD(32'h0), .HALT_RUN(5)) uMain (
    .clk(clk), .reset(reset), .start_i(start), .stop_i(stop), .clear_i(clear),
    .evt_inc_i(evtInc), .evt_dec_i(evtDec), .instr_i(instr), .snap_i(snap),
    .rd_addr_i(rdAddr), .rd_shadow_i(rdShadow), .rd_data_o(rdMain), .ovf_o(ovfMain),
    .running_o(runMain), .done_o(doneMain)
  );

  perf_counter_unit #(.NUM_EVT(NE), .CNT_W(8), .SATURATE(1'b1), .HALT_WORD(32'h0), .HALT_RUN(5)) uSat (
    .clk(clk), .reset(reset), .start_i(start), .stop_i(stop), .clear_i(clear),
    .evt_inc_i(evtInc), .evt_dec_i(evtDec), .instr_i(instr), .snap_i(snap),
    .rd_addr_i(rdAddr), .rd_shadow_i(rdShadow), .rd_data_o(rdSat), .ovf_o(ovfSat),
    .running_o(runSat), .done_o(doneSat)
  );

  perf_counter_unit #(.NUM_EVT(NE), .CNT_W(8), .SATURATE(1'b0), .HALT_WORD(32'h0), .HALT_RUN(5)) uWrap (
    .clk(clk), .reset(reset), .start_i(start), .stop_i(stop), .clear_i(clear),
    .evt_inc_i(evtInc), .evt_dec_i(evtDec), .instr_i(instr), .snap_i(snap),
    .rd_addr_i(rdAddr), .rd_shadow_i(rdShadow), .rd_data_o(rdWrap), .ovf_o(ovfWrap),
    .running_o(runWrap), .done_o(doneWrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic chkCtl(input string tag, input logic run, input logic done);
    chk({tag, "_run_main"},  64'(runMain),  64'(run));
    chk({tag, "_done_main"}, 64'(doneMain), 64'(done));
    chk({tag, "_run_sat"},   64'(runSat),   64'(run));
    chk({tag, "_done_wrap"}, 64'(doneWrap), 64'(done));
  endtask

  task automatic chkOvf(input string tag, input logic [NE:0] eMain, input logic [NE:0] eSmall);
    chk({tag, "_ovf_main"}, 64'(ovfMain), 64'(eMain));
    chk({tag, "_ovf_sat"},  64'(ovfSat),  64'(eSmall));
    chk({tag, "_ovf_wrap"}, 64'(ovfWrap), 64'(eSmall));
  endtask

  task automatic tick();
    rdExp_t e;
    @(posedge clk);
    #1;
    if (rdQ.size() > 0) begin
      e = rdQ.pop_front();
      chk($sformatf("rd%0d%s_main", e.addr, e.sh ? "s" : "l"), 64'(rdMain), 64'(e.eMain));
      chk($sformatf("rd%0d%s_sat",  e.addr, e.sh ? "s" : "l"), 64'(rdSat),  64'(e.eSat));
      chk($sformatf("rd%0d%s_wrap", e.addr, e.sh ? "s" : "l"), 64'(rdWrap), 64'(e.eWrap));
    end
  endtask

  task automatic issueRead(input int addr, input bit sh, input logic [31:0] eM,
                           input logic [7:0] eS, input logic [7:0] eW);
    rdExp_t e;
    rdAddr   = AW'(addr);
    rdShadow = sh;
    e.addr = addr; e.sh = sh; e.eMain = eM; e.eSat = eS; e.eWrap = eW;
    rdQ.push_back(e);
    tick();
  endtask

  task automatic pulseClear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; snap = 1'b0;
    evtInc = '0; evtDec = '0; instr = 32'h0000_0013; rdAddr = '0; rdShadow = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_rd_main", 64'(rdMain), 64'd0);
    chkOvf("rst", '0, '0);
    chkCtl("rst", 1'b0, 1'b0);
    reset = 1'b0;

    // Basic run: 10 cycles, 4 increments on counter 1, then stop
    pulseStart();
    chkCtl("start", 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      evtInc = (i % 2 == 1 && i < 8) ? 4'b0001 : 4'b0000;
      tick();
    end
    evtInc = '0;
    stop = 1'b1; tick(); stop = 1'b0;
    chkCtl("stop", 1'b0, 1'b1);
    issueRead(0, 1'b0, 32'd11, 8'd11, 8'd11);
    issueRead(1, 1'b0, 32'd4, 8'd4, 8'd4);
    pulseStart();
    chkCtl("start_in_halt", 1'b0, 1'b1);
    issueRead(0, 1'b0, 32'd11, 8'd11, 8'd11);

    // Decrement handling on counter 2
    pulseClear();
    chkCtl("clear", 1'b0, 1'b0);
    pulseStart();
    evtDec = 4'b0010; tick(); evtDec = '0;
    issueRead(2, 1'b0, 32'd0, 8'd0, 8'd0);
    repeat (3) begin evtInc = 4'b0010; tick(); end
    evtInc = 4'b0010; evtDec = 4'b0010; tick();
    evtInc = '0; evtDec = '0;
    issueRead(2, 1'b0, 32'd3, 8'd3, 8'd3);
    evtDec = 4'b0010; tick(); evtDec = '0;
    issueRead(2, 1'b0, 32'd2, 8'd2, 8'd2);
    chkOvf("dec", '0, '0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Snapshot at cycle-count 7, then live reads and an out-of-range read
    pulseClear();
    pulseStart();
    repeat (7) tick();
    snap = 1'b1; tick(); snap = 1'b0;
    issueRead(0, 1'b1, 32'd7, 8'd7, 8'd7);
    issueRead(0, 1'b0, 32'd9, 8'd9, 8'd9);
    issueRead(0, 1'b0, 32'd10, 8'd10, 8'd10);
    issueRead(NE + 1, 1'b0, 32'd0, 8'd0, 8'd0);
    issueRead(NE + 1, 1'b1, 32'd0, 8'd0, 8'd0);
    chkCtl("snap", 1'b1, 1'b0);

    // Halt detection: 4 zeros do not halt, 5 consecutive zeros do
    pulseClear();
    pulseStart();
    instr = 32'h0;
    repeat (4) tick();
    instr = 32'h0000_0013; tick();
    chkCtl("halt_short", 1'b1, 1'b0);
    instr = 32'h0;
    repeat (4) tick();
    chkCtl("halt_4th", 1'b1, 1'b0);
    tick();
    chkCtl("halt_5th", 1'b0, 1'b1);
    instr = 32'h0000_0013;
    issueRead(0, 1'b0, 32'd10, 8'd10, 8'd10);
    repeat (3) tick();
    issueRead(0, 1'b0, 32'd10, 8'd10, 8'd10);

    // Saturation and wrap: 300 increments on counter 1
    pulseClear();
    pulseStart();
    evtInc = 4'b0001;
    repeat (300) tick();
    evtInc = '0;
    stop = 1'b1; tick(); stop = 1'b0;
    chkOvf("sat", 5'b00000, 5'b00011);
    issueRead(1, 1'b0, 32'd300, 8'd255, 8'd44);
    issueRead(0, 1'b0, 32'd301, 8'd255, 8'd45);

    // Clear in HALTED drops flags, then start is accepted again
    pulseClear();
    chkOvf("clr_halt", '0, '0);
    chkCtl("clr_halt", 1'b0, 1'b0);
    issueRead(1, 1'b0, 32'd0, 8'd0, 8'd0);
    pulseStart();
    chkCtl("restart", 1'b1, 1'b0);

    // Asynchronous reset mid-RUN
    evtInc = 4'b0001;
    repeat (3) tick();
    evtInc = '0;
    issueRead(1, 1'b0, 32'd3, 8'd3, 8'd3);
    #3 reset = 1'b1;
    #1;
    chk("arst_rd_main", 64'(rdMain), 64'd0);
    chk("arst_rd_sat",  64'(rdSat),  64'd0);
    chkOvf("arst", '0, '0);
    chkCtl("arst", 1'b0, 1'b0);
    #1 reset = 1'b0;
    repeat (2) tick();
    chkCtl("post_arst", 1'b0, 1'b0);
    issueRead(0, 1'b0, 32'd0, 8'd0, 8'd0);
    pulseStart();
    repeat (2) tick();
    issueRead(0, 1'b0, 32'd2, 8'd2, 8'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/perf_counter_unit.md
# perf_counter_unit

Synthesisable performance-monitor block for the RV32I pipelined core.
- Counts clock cycles and up to NUM_EVT pipeline event streams (instruction fetch, stall, flush, mispredict, …), with per-event decrement for squashed instructions.
- Detects end-of-program from the fetched instruction word and freezes itself.
- Exposes all counters through a registered read port with a snapshot bank.
- Sits beside the core in top-level; software or a bench reads results to derive CPI.

## Interface
Parameters:
- NUM_EVT, 4, number of event counters (1..15); counter 0 is always the cycle counter
- CNT_W, 32, counter width in bits (8..64)
- SATURATE, 1, 1 = counters saturate at all-ones, 0 = counters wrap
- HALT_WORD, 32'h0000_0000, instruction word that signals end of program
- HALT_RUN, 5, consecutive HALT_WORD cycles required to halt (2..255)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start_i  in  1  IDLE → RUN
- stop_i  in  1  RUN → HALTED
- clear_i  in  1  synchronous clear of counters, shadows and flags; → IDLE
- evt_inc_i  in  NUM_EVT  increment pulse for counter k+1
- evt_dec_i  in  NUM_EVT  decrement pulse for counter k+1
- instr_i  in  32  instruction word currently fetched
- snap_i  in  1  copy all live counters into the shadow bank
- rd_addr_i  in  AW=$clog2(NUM_EVT+1)  counter index
- rd_shadow_i  in  1  1 = read shadow bank, 0 = read live bank
- rd_data_o  out  CNT_W  registered read data
- ovf_o  out  NUM_EVT+1  sticky overflow flag per counter
- running_o  out  1  state == RUN
- done_o  out  1  state == HALTED

## Operation
- States:
  - IDLE (reset state): nothing counts. start_i → RUN.
  - RUN: counters update. stop_i or halt detection → HALTED.
  - HALTED: counters frozen; start_i is ignored.
- clear_i → IDLE from any state.
- Priority: clear_i > stop_i/halt > start_i.
- Counting happens only in cycles that begin in RUN. The cycle in which start_i is sampled is not counted; the cycle in which stop or halt is sampled is counted.
- Counter 0 increments once per RUN cycle.
- Counter k+1 changes per cycle:
  - +1 on inc only
  - −1 on dec only
  - unchanged on both or neither
- Decrement at 0 holds at 0; ovf is not set.
- Increment at all-ones:
  - SATURATE=1: holds at all-ones and sets ovf[k].
  - SATURATE=0: wraps to 0 and sets ovf[k].
- ovf bits are sticky until clear_i or reset.
- Halt detector (RUN only):
  - A run counter increments while instr_i == HALT_WORD and resets to 0 otherwise; it saturates at HALT_RUN.
  - When the HALT_RUN-th consecutive match is sampled, the state becomes HALTED on that edge.
  - Leaving RUN resets the run counter.
- snap_i is honoured in every state. The shadow bank receives the live values as they stand before that cycle's update. snap_i and clear_i in the same cycle: clear wins.
- Read: rd_data_o is 0 when rd_addr_i > NUM_EVT.

## Timing
- Reset values:
  - rd_data_o = 0, ovf_o = 0, running_o = 0, done_o = 0
  - all counters, shadows and the run counter = 0; state = IDLE
- running_o and done_o are registered and reflect state after the edge.
- Read latency is 1 cycle: rd_data_o at edge n+1 reflects rd_addr_i/rd_shadow_i sampled at edge n. The value read is the bank content before edge n's update.
- Counter update latency is 1 cycle: an event sampled at edge n is visible in the live bank after edge n.
- Asynchronous reset mid-RUN clears everything immediately. Counting resumes only after a new start_i.

## Structure
- perf_counter_pkg:
  - state enum pc_state_t {PC_IDLE, PC_RUN, PC_HALTED}
  - localparam for the cycle-counter index (0)
  - default HALT_WORD
- Sub-module perf_counter_cell (parameter CNT_W, SATURATE; ports en, inc, dec, clr, q, ovf):
  - instantiated NUM_EVT+1 times in a generate loop
  - cell 0 is driven with inc=1, dec=0
- Top level holds the FSM, halt detector, shadow bank and read mux.

## Test plan
- Reset, start_i, then 10 RUN cycles with evt_inc_i[0] pulsed 4 times, then stop_i. Expected after the stop edge:
  - counter 0 = 11, counter 1 = 4
  - done_o = 1; reads return these values with 1-cycle latency
- Decrement handling on counter 2:
  - inc and dec in the same cycle → unchanged
  - dec at 0 → stays 0, ovf_o[2] = 0
  - 3 incs followed by 1 dec → 2
- CNT_W=8, SATURATE=1: 300 incs → counter = 255, ovf set. Repeat with SATURATE=0: 300 incs → counter = 44, ovf set.
- Halt detection with HALT_RUN=5:
  - instr_i = 0 for 4 cycles, then nonzero → stays in RUN
  - later, 5 consecutive zeros → done_o rises after the 5th; counter 0 stops advancing
- Snapshot: snap_i at cycle-count 7 while still running. Expected:
  - shadow read of index 0 returns 7
  - live read returns the growing value
  - rd_addr_i = NUM_EVT+1 returns 0
- Assert reset mid-RUN with counters nonzero → all outputs 0 immediately. clear_i in HALTED → IDLE, ovf_o = 0, start_i is accepted again.
